// File: rtl/imem_fetch_responder.sv
// -----------------------------------------------------------------------------
// imem_fetch_responder
//
// Responder side of the instruction-fetch memory interface. A fetch request
// (mem_read held high with a byte address on mem_addr) is captured, held for
// LATENCY wait-state cycles and answered with a single registered word on
// mem_data, qualified by a one-cycle mem_ready pulse. The word comes from an
// internal word-addressed array that is filled through an independent load
// port. Misaligned or out-of-range fetches return NOP_WORD with access_err.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   mem_addr    byte address of the fetch request
//   mem_read    fetch request, held high by the initiator while requesting
//   mem_data    returned instruction word (registered, holds when idle)
//   mem_ready   one-cycle pulse, mem_data valid while high
//   load_en     write load_data into the array this cycle
//   load_addr   byte address for the load (bad addresses are ignored)
//   load_data   word to load
//   busy        high whenever the responder is not idle
//   access_err  one-cycle pulse alongside an erroneous response
//   resp_count  saturating count of mem_ready pulses
// -----------------------------------------------------------------------------
module imem_fetch_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LATENCY  = 2,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  output logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy,
  output logic        access_err,
  output logic [15:0] resp_count
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam logic [3:0]  LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_ready_q, mem_ready_d;
  logic        access_err_q, access_err_d;
  logic [15:0] resp_count_q, resp_count_d;

  logic [31:0] mem_array [DEPTH];
  logic [31:0] rd_word;

  // Misaligned, or any address bit above the array's word index set.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  function automatic logic [AW-1:0] addr_idx(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

  // Instruction store: not reset, written independently of the fetch FSM.
  always_ff @(posedge clk) begin
    if (load_en && !addr_bad(load_addr)) begin
      mem_array[addr_idx(load_addr)] <= load_data;
    end
  end

  // Combinational read sampled into mem_data_q on the response edge, so a
  // load to the same word on that edge is seen only by later fetches.
  always_comb begin
    rd_word = mem_array[addr_idx(req_addr_q)];
  end

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    cnt_d        = cnt_q;
    mem_data_d   = mem_data_q;
    mem_ready_d  = 1'b0;
    access_err_d = 1'b0;
    resp_count_d = resp_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_read) begin
          req_addr_d = mem_addr;
          cnt_d      = LAT;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Priority: abort, then redirect, then countdown.
        if (!mem_read) begin
          state_d = ST_IDLE;
        end else if (mem_addr != req_addr_q) begin
          req_addr_d = mem_addr;
          cnt_d      = LAT;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = ST_RESP;
          mem_ready_d = 1'b1;
          if (addr_bad(req_addr_q)) begin
            mem_data_d   = NOP_WORD;
            access_err_d = 1'b1;
          end else begin
            mem_data_d = rd_word;
          end
          if (resp_count_q != 16'hFFFF) begin
            resp_count_d = resp_count_q + 16'd1;
          end
        end
      end

      ST_RESP: begin
        // One dead edge lets the initiator present its next address.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_addr_q   <= '0;
      cnt_q        <= '0;
      mem_data_q   <= '0;
      mem_ready_q  <= 1'b0;
      access_err_q <= 1'b0;
      resp_count_q <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      cnt_q        <= cnt_d;
      mem_data_q   <= mem_data_d;
      mem_ready_q  <= mem_ready_d;
      access_err_q <= access_err_d;
      resp_count_q <= resp_count_d;
    end
  end

  assign mem_data   = mem_data_q;
  assign mem_ready  = mem_ready_q;
  assign access_err = access_err_q;
  assign resp_count = resp_count_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_fetch_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_responder
//
// Two responders share clock, reset and load port: u_a with LATENCY=2 and
// u_b with LATENCY=0. Stimulus tasks push expected responses (word, error
// flag, count and arrival cycle) into per-instance queues; a monitor pops and
// compares whenever mem_ready is seen. The reference keeps a plain word
// array and derives the arrival cycle from request timing arithmetic.
// -----------------------------------------------------------------------------
module tb_imem_fetch_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] a_addr, b_addr, a_data, b_data;
  logic        a_read, b_read, a_ready, b_ready, a_err, b_err, a_busy, b_busy;
  logic [15:0] a_cnt, b_cnt;
  logic        load_en;
  logic [31:0] load_addr, load_data;

  imem_fetch_responder #(.DEPTH(DEPTH), .LATENCY(2), .NOP_WORD(NOP)) u_a (
    .clk(clk), .rst_n(rst_n), .mem_addr(a_addr), .mem_read(a_read),
    .mem_data(a_data), .mem_ready(a_ready), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(a_busy),
    .access_err(a_err), .resp_count(a_cnt)
  );

  imem_fetch_responder #(.DEPTH(DEPTH), .LATENCY(0), .NOP_WORD(NOP)) u_b (
    .clk(clk), .rst_n(rst_n), .mem_addr(b_addr), .mem_read(b_read),
    .mem_data(b_data), .mem_ready(b_ready), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(b_busy),
    .access_err(b_err), .resp_count(b_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] ref_mem [DEPTH];
  int unsigned cnt_m [2];
  int          nxt [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  function automatic int lat(input int inst);
    return (inst == 0) ? 2 : 0;
  endfunction

  function automatic logic busy_of(input int inst);
    return (inst == 0) ? a_busy : b_busy;
  endfunction

  task automatic drive(input int inst, input logic [31:0] addr, input logic rd);
    if (inst == 0) begin
      a_addr = addr;
      a_read = rd;
    end else begin
      b_addr = addr;
      b_read = rd;
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(negedge clk);
    load_en = 1'b0;
    if (!bad(addr)) ref_mem[int'(addr >> 2)] = data;
  endtask

  // Issue one fetch; optionally redirect one cycle after capture, keep
  // mem_read high afterwards, or load on the response edge.
  task automatic fetch(input int inst, input logic [31:0] addr, input bit keep,
                       input bit redir, input logic [31:0] raddr,
                       input bit ld, input logic [31:0] laddr, input logic [31:0] ldata);
    int          e0;
    int          rdy;
    logic [31:0] fa;
    exp_t        e;
    drive(inst, addr, 1'b1);
    e0 = (cyc + 1 > nxt[inst]) ? cyc + 1 : nxt[inst];
    while (cyc < e0) @(negedge clk);
    check($sformatf("busy_capture[%0d]", inst), 32'(busy_of(inst)), 32'd1);
    fa  = addr;
    rdy = e0 + lat(inst) + 1;
    if (redir) begin
      drive(inst, raddr, 1'b1);
      fa  = raddr;
      rdy = e0 + 1 + lat(inst) + 1;
    end
    if (cnt_m[inst] < 32'hFFFF) cnt_m[inst]++;
    e.err  = bad(fa);
    e.data = bad(fa) ? NOP : ref_mem[int'(fa >> 2)];
    e.cnt  = 16'(cnt_m[inst]);
    e.cyc  = rdy;
    if (inst == 0) q_a.push_back(e);
    else           q_b.push_back(e);
    while (cyc < rdy) begin
      if (ld && cyc == rdy - 1) begin
        load_en   = 1'b1;
        load_addr = laddr;
        load_data = ldata;
      end
      @(negedge clk);
    end
    if (ld) begin
      load_en = 1'b0;
      if (!bad(laddr)) ref_mem[int'(laddr >> 2)] = ldata;
    end
    check($sformatf("busy_resp[%0d]", inst), 32'(busy_of(inst)), 32'd1);
    if (!keep) drive(inst, fa, 1'b0);
    nxt[inst] = rdy + 2;
  endtask

  task automatic f(input int inst, input logic [31:0] addr);
    fetch(inst, addr, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_data_a"}, a_data, 32'd0);
    check({tag, "_ready_a"}, 32'(a_ready), 32'd0);
    check({tag, "_err_a"}, 32'(a_err), 32'd0);
    check({tag, "_cnt_a"}, 32'(a_cnt), 32'd0);
    check({tag, "_busy_a"}, 32'(a_busy), 32'd0);
    check({tag, "_data_b"}, b_data, 32'd0);
    check({tag, "_ready_b"}, 32'(b_ready), 32'd0);
    check({tag, "_err_b"}, 32'(b_err), 32'd0);
    check({tag, "_cnt_b"}, 32'(b_cnt), 32'd0);
    check({tag, "_busy_b"}, 32'(b_busy), 32'd0);
  endtask

  task automatic mon(input int inst, input logic rdy, input logic err,
                     input logic [31:0] data, input logic [15:0] cnt);
    exp_t e;
    int   sz;
    sz = (inst == 0) ? q_a.size() : q_b.size();
    if (rdy) begin
      if (sz == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_ready[%0d] at cycle %0d: got mem_ready=1 required 0", inst, cyc);
      end else begin
        if (inst == 0) e = q_a.pop_front();
        else           e = q_b.pop_front();
        check($sformatf("resp_data[%0d]", inst), data, e.data);
        check($sformatf("resp_err[%0d]", inst), 32'(err), 32'(e.err));
        check($sformatf("resp_count[%0d]", inst), 32'(cnt), 32'(e.cnt));
        check($sformatf("resp_cycle[%0d]", inst), 32'(cyc), 32'(e.cyc));
      end
    end else if (err) begin
      n_checks++;
      n_err++;
      $display("FAIL stray_err[%0d] at cycle %0d: got access_err=1 required 0", inst, cyc);
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_ready, a_err, a_data, a_cnt);
    mon(1, b_ready, b_err, b_data, b_cnt);
  end

  initial begin
    int          e0;
    logic [31:0] addr;
    logic [31:0] raddr;
    a_addr = '0; a_read = 1'b0; b_addr = '0; b_read = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    rst_n = 1'b0;
    cnt_m = '{0, 0};
    nxt   = '{0, 0};
    #1;
    chk_reset("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      do_load(32'(i * 4), (i < 4) ? 32'hA0 + 32'(i) : $urandom);
    end

    // Basic fetch, then mem_data holds and busy drops after RESP.
    f(0, 32'h8);
    @(negedge clk);
    check("data_hold", a_data, 32'hA2);
    check("busy_idle", 32'(a_busy), 32'd0);

    // Back-to-back stream with mem_read held high.
    fetch(0, 32'h0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    fetch(0, 32'h4, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    fetch(0, 32'h8, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);

    // Redirect one cycle after capture.
    fetch(0, 32'h4, 1'b0, 1'b1, 32'hC, 1'b0, 32'd0, 32'd0);

    // Abort in WAIT: no response, count unchanged.
    drive(0, 32'h10, 1'b1);
    e0 = (cyc + 1 > nxt[0]) ? cyc + 1 : nxt[0];
    while (cyc < e0) @(negedge clk);
    check("busy_abort_wait", 32'(a_busy), 32'd1);
    drive(0, 32'h10, 1'b0);
    @(negedge clk);
    check("busy_after_abort", 32'(a_busy), 32'd0);
    check("count_after_abort", 32'(a_cnt), cnt_m[0]);
    nxt[0] = cyc + 1;
    repeat (4) @(negedge clk);

    // Erroneous fetches and ignored loads.
    f(0, 32'h6);
    f(0, 32'(DEPTH * 4));
    f(1, 32'h6);
    do_load(32'h2, 32'hDEAD_0002);
    do_load(32'(DEPTH * 4), 32'hDEAD_1000);
    f(0, 32'h0);
    f(1, 32'h0);

    // Load on the response edge: old word returned, new word later.
    fetch(0, 32'h8, 1'b0, 1'b0, 32'd0, 1'b1, 32'h8, 32'hBEEF);
    f(0, 32'h8);
    f(1, 32'h8);
    fetch(1, 32'h4, 1'b0, 1'b1, 32'h14, 1'b0, 32'd0, 32'd0);

    // Randomised traffic on both instances.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) do_load(32'($urandom_range(0, 15) * 4), $urandom);
      case ($urandom_range(0, 5))
        0:       addr = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
        1:       addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 7) * 4);
        default: addr = 32'($urandom_range(0, 15) * 4);
      endcase
      raddr = 32'($urandom_range(0, 15) * 4);
      if (raddr == addr) raddr = raddr ^ 32'h4;
      fetch(int'($urandom_range(0, 1)), addr, 1'b0, ($urandom_range(0, 3) == 0), raddr,
            1'b0, 32'd0, 32'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset while a request is in WAIT: request dropped.
    drive(0, 32'h4, 1'b1);
    e0 = (cyc + 1 > nxt[0]) ? cyc + 1 : nxt[0];
    while (cyc < e0) @(negedge clk);
    rst_n = 1'b0;
    drive(0, 32'h4, 1'b0);
    #1;
    chk_reset("midreset");
    @(negedge clk);
    rst_n  = 1'b1;
    cnt_m  = '{0, 0};
    nxt[0] = cyc + 1;
    nxt[1] = cyc + 1;
    repeat (6) @(negedge clk);

    // Saturation of resp_count on the LATENCY=0 instance.
    force u_b.resp_count_q = 16'hFFFE;
    @(negedge clk);
    release u_b.resp_count_q;
    cnt_m[1] = 32'hFFFE;
    check("count_preset", 32'(b_cnt), 32'hFFFE);
    f(1, 32'h6);
    f(1, 32'h0);
    f(1, 32'h4);
    f(0, 32'hC);

    repeat (3) @(negedge clk);
    check("queue_a_drained", 32'(q_a.size()), 32'd0);
    check("queue_b_drained", 32'(q_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Responder side of the instruction-fetch memory interface. It accepts word fetch requests on mem_addr/mem_read and returns one instruction word per request on mem_data/mem_ready after a programmable wait-state latency. It holds a word-addressed instruction array that is preloaded through a separate load port. It sits between the fetch unit and the instruction store, and doubles as the bench memory model for fetch-side verification.

Parameters:
DEPTH, 1024, number of 32-bit words in the instruction array (power of 2).
LATENCY, 2, wait-state cycles between request capture and response (0..15).
NOP_WORD, 32'h00000013, word returned on erroneous access.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
mem_addr  input  32  byte address of the fetch request
mem_read  input  1  fetch request; held high by the initiator while requesting
mem_data  output  32  returned instruction word, registered
mem_ready  output  1  one-cycle pulse; mem_data is valid while high
load_en  input  1  write one word into the array this cycle
load_addr  input  32  byte address for the load
load_data  input  32  word to load
busy  output  1  high whenever the state is not IDLE
access_err  output  1  one-cycle pulse coincident with an erroneous response
resp_count  output  16  saturating count of mem_ready pulses

Behaviour:
- Reset (asynchronous, active-low on rst_n; clock clk):
  - mem_data=0, mem_ready=0, access_err=0, resp_count=0, busy=0.
  - State goes to IDLE and the wait counter clears.
  - Array contents are not reset.
  - Reset asserted mid-request drops the request; no response is ever issued for it.
- Word index: idx = addr[log2(DEPTH)+1:2].
  - Error if addr[1:0]!=0, or if addr[31:log2(DEPTH)+2]!=0 (out of range).
- State IDLE:
  - mem_read=1 at edge E0 captures mem_addr into req_addr, loads cnt=LATENCY, and moves to WAIT.
- State WAIT, at each edge:
  - mem_read=0: abort. Go to IDLE with no response.
  - mem_addr!=req_addr: the request was redirected, e.g. by a fetch flush. Recapture mem_addr, reload cnt=LATENCY, stay in WAIT.
  - cnt!=0: decrement cnt.
  - cnt==0: go to RESP. Register mem_ready=1 and mem_data=array[idx], or NOP_WORD with access_err=1 on error. Increment resp_count, saturating at 16'hFFFF.
- Latency: mem_ready rises at edge E0+LATENCY+1 and stays high for exactly one cycle.
- State RESP:
  - Next edge clears mem_ready and access_err and goes to IDLE unconditionally.
  - A following request is accepted no earlier than the edge after that, so the initiator has one edge to update mem_addr.
  - Minimum request spacing is LATENCY+3 cycles.
- mem_data holds its last value when mem_ready is low.
- Load port:
  - Operates in every state, independent of the fetch FSM.
  - Writes array[load idx] at the edge.
  - A misaligned or out-of-range load_addr is ignored; it does not raise access_err.
- Load and response on the same edge to the same index: read-before-write. The response carries the old word; the new word is visible on later fetches.
- Redirect and abort priority: abort (mem_read=0) beats redirect, and redirect beats countdown.

Test Plan:
1. Basic fetch, LATENCY=2. Preload array[0..3] = 0xA0..0xA3. Hold mem_read=1, mem_addr=0x8. Required: mem_ready pulses at E0+3, mem_data=0xA2, access_err=0, resp_count=1, busy high from E0 through the RESP cycle.
2. Sequential stream. Initiator drops mem_read for 0 cycles and advances mem_addr 0x0, 0x4, 0x8 after each mem_ready. Required: data 0xA0, 0xA1, 0xA2 in order; pulses spaced 5 cycles apart; resp_count=3.
3. Redirect and abort.
   - Change mem_addr from 0x4 to 0xC one cycle after capture: single response 0xA3 at 3 cycles after the redirect edge.
   - Separately, drop mem_read in WAIT: no mem_ready, state returns to IDLE, resp_count unchanged.
4. Errors.
   - mem_addr=0x6: mem_data=0x00000013 with access_err=1.
   - mem_addr=DEPTH*4: same response.
   - load_addr=0x2: array unchanged.
5. Same-edge load and response. load_en to 0x8 with 0xBEEF on the response edge of a fetch of 0x8: response 0xA2, next fetch of 0x8 returns 0xBEEF. Then LATENCY=0: mem_ready at E0+1.
6. Reset and saturation.
   - Assert rst_n low in WAIT: all outputs 0 and no later mem_ready.
   - Force resp_count to 0xFFFF (bench preload via 65535 fetches at LATENCY=0): it stays 0xFFFF on the next response.
